// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
// tdm_demux4 : receive side of the 4-channel TDM link. Aligns to fsync,
// flywheels across missing syncs, and commits whole frames to ch_out.
// Optional frame parity slot: define TDM_DEMUX_PARITY_EN.       Rev 1.0
// ============================================================================
module tdm_demux4 #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 1,
  parameter int MISS_MAX  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [SLOT_W-1:0]           din,
  input  logic                        fsync,
  output logic [NUM_SLOTS*SLOT_W-1:0] ch_out,
  output logic                        frame_valid,
  output logic                        locked,
  output logic                        sync_err,
  output logic                        par_err
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME_LEN = NUM_SLOTS + 1;
`else
  localparam int FRAME_LEN = NUM_SLOTS;
`endif
  localparam int DW     = NUM_SLOTS * SLOT_W;
  localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int MISS_W = $clog2(MISS_MAX + 1);

  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(FRAME_LEN - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [MISS_W-1:0] miss_q;
  logic [DW-1:0]     shadow_q;
  logic [DW-1:0]     ch_q;
  logic [DW-1:0]     frame_d;
  logic              commit_q;
  logic              fv_q;
  logic              serr_q;

  // Shadow frame with the current sample merged in at the active slot.
  always_comb begin
    frame_d = shadow_q;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        frame_d[k*SLOT_W +: SLOT_W] = din;
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic perr_q;
  logic parity_ok;

  assign parity_ok = ((^shadow_q) == din[0]);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      miss_q   <= '0;
      shadow_q <= '0;
      ch_q     <= '0;
      commit_q <= 1'b0;
      fv_q     <= 1'b0;
      serr_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      // frame_valid trails the commit edge by one cycle regardless of en.
      fv_q     <= commit_q;
      commit_q <= 1'b0;
      serr_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      perr_q   <= 1'b0;
`endif
      if (en) begin
        case (state_q)
          HUNT: begin
            if (fsync) begin
              shadow_q[SLOT_W-1:0] <= din;
              cnt_q                <= CNT_ONE;
              miss_q               <= '0;
              state_q              <= LOCK;
            end
          end
          LOCK: begin
            if (fsync && (cnt_q != '0)) begin
              serr_q               <= 1'b1;
              shadow_q[SLOT_W-1:0] <= din;
              cnt_q                <= CNT_ONE;
              miss_q               <= '0;
            end else if (cnt_q == '0) begin
              if (fsync) begin
                shadow_q[SLOT_W-1:0] <= din;
                cnt_q                <= CNT_ONE;
                miss_q               <= '0;
              end else if (miss_q == MISS_LAST) begin
                state_q <= HUNT;
                cnt_q   <= '0;
                miss_q  <= '0;
              end else begin
                shadow_q[SLOT_W-1:0] <= din;
                cnt_q                <= CNT_ONE;
                miss_q               <= miss_q + MISS_ONE;
              end
            end else if (cnt_q == LAST_SLOT) begin
              cnt_q <= '0;
`ifdef TDM_DEMUX_PARITY_EN
              if (parity_ok) begin
                ch_q     <= shadow_q;
                commit_q <= 1'b1;
              end else begin
                perr_q <= 1'b1;
              end
`else
              ch_q     <= frame_d;
              commit_q <= 1'b1;
`endif
            end else begin
              shadow_q <= frame_d;
              cnt_q    <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= HUNT;
            cnt_q   <= '0;
            miss_q  <= '0;
          end
        endcase
      end
    end
  end

  assign ch_out      = ch_q;
  assign frame_valid = fv_q;
  assign locked      = (state_q == LOCK);
  assign sync_err    = serr_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign par_err     = perr_q;
`else
  assign par_err     = 1'b0;
`endif

endmodule
`default_nettype wire
